// File: rtl/m_src_fifo.sv
// m_src_fifo: 64-bit first-word-fall-through source staging FIFO with last tag, registered flags and sticky ovf/udf
module m_src_fifo #(
  parameter int DEPTH_LOG2 = 5,
  parameter int AE_LEVEL = 2,
  parameter int AF_LEVEL = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [63:0]           wr_data,
  input  logic                  wr_last,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  input  logic                  m_src_getn,
  output logic [63:0]           m_src,
  output logic                  m_src_last,
  output logic                  m_src_empty,
  output logic                  m_src_almost_empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  output logic                  udf
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] AE_C = AE_LEVEL[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] AF_C = AF_LEVEL[DEPTH_LOG2:0];
  logic [64:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0] count, cnt_n;
  logic clr, is_full, is_empty, wr_ok, rd_ok;
  always_comb begin
    clr = wb_rst_i || flush;
    is_full = count == DEPTH_C;
    is_empty = count == '0;
    wr_ok = wr_en && !is_full && !clr;
    rd_ok = !m_src_getn && !is_empty && !clr;
    cnt_n = clr ? '0 : count + (DEPTH_LOG2+1)'(wr_ok) - (DEPTH_LOG2+1)'(rd_ok);
  end
  always_ff @(posedge wb_clk_i) if (wr_ok) mem[wptr] <= {wr_last, wr_data};
  always_ff @(posedge wb_clk_i) begin
    wptr <= clr ? '0 : wptr + DEPTH_LOG2'(wr_ok);
    rptr <= clr ? '0 : rptr + DEPTH_LOG2'(rd_ok);
    count <= cnt_n;
    level <= cnt_n;
    m_src_empty <= cnt_n == '0;
    m_src_almost_empty <= cnt_n <= AE_C;
    wr_full <= cnt_n == DEPTH_C;
    wr_almost_full <= DEPTH_C - cnt_n <= AF_C;
    ovf <= wb_rst_i ? 1'b0 : ovf || (!flush && wr_en && is_full);
    udf <= wb_rst_i ? 1'b0 : udf || (!flush && !m_src_getn && is_empty);
  end
  always_comb begin
    m_src = mem[rptr][63:0];
    m_src_last = !m_src_empty && mem[rptr][64];
  end
endmodule

// File: tb/tb_m_src_fifo.sv
// tb_m_src_fifo: directed plus randomized checks of m_src_fifo against a queue reference model
module tb_m_src_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic wr_en = 1'b0;
  logic [63:0] wr_data = '0;
  logic wr_last = 1'b0;
  logic getn = 1'b1;
  logic wr_full, wr_almost_full, m_src_last, m_src_empty, m_src_almost_empty, ovf, udf;
  logic [63:0] m_src;
  logic [5:0] level;
  logic [64:0] q[$];
  logic movf = 1'b0;
  logic mudf = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  m_src_fifo dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .flush(flush),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .wr_last(wr_last),
    .wr_full(wr_full),
    .wr_almost_full(wr_almost_full),
    .m_src_getn(getn),
    .m_src(m_src),
    .m_src_last(m_src_last),
    .m_src_empty(m_src_empty),
    .m_src_almost_empty(m_src_almost_empty),
    .level(level),
    .ovf(ovf),
    .udf(udf)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    int n;
    n = q.size();
    chk("level", 64'(level), 64'(n));
    chk("empty", 64'(m_src_empty), 64'(n == 0));
    chk("almost_empty", 64'(m_src_almost_empty), 64'(n <= 2));
    chk("full", 64'(wr_full), 64'(n == 32));
    chk("almost_full", 64'(wr_almost_full), 64'(32 - n <= 4));
    chk("ovf", 64'(ovf), 64'(movf));
    chk("udf", 64'(udf), 64'(mudf));
    chk("last", 64'(m_src_last), 64'(n != 0 && q[0][64]));
    if (n != 0) chk("data", m_src, q[0][63:0]);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b0;
    wr_en = 1'b1;
    getn = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    movf = 1'b0;
    mudf = 1'b0;
    check_all();
  endtask
  task automatic step(input logic we, input logic [63:0] d, input logic l, input logic gn, input logic fl = 1'b0);
    int n;
    @(negedge clk);
    rst = 1'b0;
    wr_en = we;
    wr_data = d;
    wr_last = l;
    getn = gn;
    flush = fl;
    n = q.size();
    if (fl) q.delete();
    else begin
      if (we && n == 32) movf = 1'b1;
      if (!gn && n == 0) mudf = 1'b1;
      if (!gn && n != 0) void'(q.pop_front());
      if (we && n != 32) q.push_back({l, d});
    end
    @(posedge clk);
    #1;
    check_all();
  endtask
  initial begin
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 64'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 64'h1000 + 64'(i), i == 4, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 33; i++) step(1'b1, {$urandom, $urandom}, 1'($urandom), 1'b1);
    step(1'b1, 64'h5a5a, 1'b1, 1'b0);
    for (int i = 0; i < 21; i++) step(1'b0, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, {$urandom, $urandom}, 1'($urandom), 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 64'h0, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 64'hAA, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1);
    step(1'b1, 64'h1, 1'b0, 1'b1);
    for (int i = 0; i < 33; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b1);
    for (int i = 0; i < 22; i++) step(1'b0, 64'h0, 1'b0, 1'b0);
    step(1'b1, 64'hDEAD, 1'b1, 1'b1, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b1);
    for (int i = 0; i < 2000; i++)
      step(($urandom % 4) != 0, {$urandom, $urandom}, 1'($urandom), ($urandom % 3) == 0, ($urandom % 200) == 0);
    do_reset();
    step(1'b0, 64'h0, 1'b0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
